id_ex_stage: RTL

- ID/EX pipeline stage, directly downstream of the decode control ROM in the 5-stage RV32I pipeline.
- Each cycle it captures the decoded control word, PC, register-file operands, register indices and all immediate formats, and presents them to EX.
- Owns load-use hazard detection: inserts one bubble and stalls IF/ID.
- Also handles EX-stall hold, branch-redirect flush, and a write-back bypass for same-cycle register writes.

---
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I pipeline: load-use bubble, EX hold, flush, WB bypass.
// Define ID_EX_STALL_CNT_EN to add saturating lu_stall_count / ex_hold_count outputs.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  aluop;
    logic [2:0]  funct3;
    logic        alu_imm;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
  } rv32i_control_word;
endpackage

module id_ex_stage
  import rv32i_types::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [31:0]       id_instr,
  input  rv32i_control_word id_ctrl,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic              wb_load_regfile,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output rv32i_control_word ex_ctrl,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_i_imm,
  output logic [XLEN-1:0]   ex_s_imm,
  output logic [XLEN-1:0]   ex_b_imm,
  output logic [XLEN-1:0]   ex_u_imm,
  output logic [XLEN-1:0]   ex_j_imm
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       lu_stall_count,
  output logic [31:0]       ex_hold_count
`endif
);

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  logic            uses_rs1, uses_rs2, hazard;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign opcode  = id_instr[6:0];
  assign rs1_idx = id_instr[19:15];
  assign rs2_idx = id_instr[24:20];
  assign rd_idx  = id_instr[11:7];

  always_comb begin
    uses_rs1 = !(opcode inside {op_lui, op_auipc, op_jal});
    uses_rs2 = opcode inside {op_br, op_store, op_reg};
    hazard   = ex_valid && ex_ctrl.mem_read && (ex_rd != 5'd0) && id_valid &&
               ((uses_rs1 && (ex_rd == rs1_idx)) || (uses_rs2 && (ex_rd == rs2_idx)));
    id_stall = !flush && (!ex_ready || hazard);
  end

  // Same-cycle WB write is not yet visible in the register file read; x0 never bypassed.
  always_comb begin
    rs1_fwd = id_rs1_data;
    rs2_fwd = id_rs2_data;
    if (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) rs1_fwd = wb_data;
    if (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) rs2_fwd = wb_data;
  end

  assign i_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
  assign s_imm = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign b_imm = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
  assign u_imm = {id_instr[31:12], 12'b0};
  assign j_imm = {{(XLEN-20){id_instr[31]}}, id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_ctrl     <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_i_imm    <= '0;
      ex_s_imm    <= '0;
      ex_b_imm    <= '0;
      ex_u_imm    <= '0;
      ex_j_imm    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (!ex_ready) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_pc       <= id_pc;
      ex_rs1_data <= rs1_fwd;
      ex_rs2_data <= rs2_fwd;
      ex_rs1      <= rs1_idx;
      ex_rs2      <= rs2_idx;
      ex_rd       <= rd_idx;
      ex_i_imm    <= i_imm;
      ex_s_imm    <= s_imm;
      ex_b_imm    <= b_imm;
      ex_u_imm    <= u_imm;
      ex_j_imm    <= j_imm;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_stall_count <= '0;
      ex_hold_count  <= '0;
    end else begin
      if (!flush && ex_ready && hazard && (lu_stall_count != '1))
        lu_stall_count <= lu_stall_count + 32'd1;
      if (!flush && !ex_ready && (ex_hold_count != '1))
        ex_hold_count <= ex_hold_count + 32'd1;
    end
  end
`endif

endmodule
